operand_collector_unit: RTL and testbench
=========================================

// Module: operand_collector_unit
// PURPOSE
//  One operand-collector (OC) slot on the initiator side of the RF bank read-request path.
//  - Accepts an issued instruction.
//  - Pushes its source-row read requests, tagged with this OC's ID, into the bank request FIFO.
//  - Captures the 256-bit operand data returned by the RF bank, matched on tag.
//  - Once all sources are present, dispatches the instruction to the execution stage.
//  Eight instances (OC_ID 0..7) share one request port and one response bus through the issue arbiter.
// PARAMETERS
//  OC_ID   3'd0  this slot's ID; upper 3 bits of every request/response tag
//  DATA_W  256   operand width (one warp register row)
//  ROW_W   3     physical row ID width
//  WARP_W  3     warp ID width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, active-high
//  alloc_valid  in   1       issue stage offers an instruction
//  alloc_ready  out  1       slot is free (IDLE)
//  alloc_warp   in   WARP_W  warp ID
//  alloc_nsrc   in   2       number of sources: 0,1,2 (3 is illegal, treated as 2)
//  alloc_src1   in   ROW_W   src1 physical row
//  alloc_src2   in   ROW_W   src2 physical row
//  alloc_dst    in   ROW_W   dest row, passed through unchanged
//  req_valid    out  1       request to bank FIFO
//  req_ready    in   1       FIFO can accept this request (room for 2 entries if req_2op)
//  req_2op      out  1       1 = push two entries (src1 then src2); 0 = push src1 only
//  req_row1     out  ROW_W   src1 row
//  req_row2     out  ROW_W   src2 row
//  req_tag1     out  4       {OC_ID,1'b0}
//  req_tag2     out  4       {OC_ID,1'b1}
//  rsp_valid    in   1       RF read data valid this cycle
//  rsp_tag      in   4       {ocid, src_sel} of returned data
//  rsp_data     in   DATA_W  returned row data
//  ex_valid     out  1       operands complete, instruction offered
//  ex_ready     in   1       execution stage accepts
//  ex_warp      out  WARP_W  latched warp
//  ex_dst       out  ROW_W   latched dest row
//  ex_op1       out  DATA_W  src1 data (zero if nsrc==0)
//  ex_op2       out  DATA_W  src2 data (zero if nsrc<2)
//  err          out  1       sticky protocol-error flag
// BEHAVIOUR
//  - Reset: state IDLE; alloc_ready=1; req_valid=0; ex_valid=0; err=0; op regs, warp, dst and
//    got1/got2 cleared. Reset mid-operation abandons the instruction: no request, no dispatch.
//  - FSM IDLE -> REQ -> WAIT -> DISP -> IDLE. All outputs are registered state, except
//    alloc_ready = (state==IDLE).
//  - IDLE, alloc_valid=1:
//    - latch warp, src rows, dst, nsrc; clear got1/got2 and op regs.
//    - next state REQ, or DISP if nsrc==0.
//  - REQ:
//    - req_valid=1; req_2op=(nsrc>=2).
//    - Rows and tags are held stable until req_ready=1.
//    - On req_valid&req_ready go to WAIT; req_valid drops the next cycle.
//    - Exactly one handshake per instruction.
//  - Response capture: in WAIT only, rsp_valid && rsp_tag[3:1]==OC_ID:
//    - sel 0 -> op1, got1=1; sel 1 -> op2, got2=1.
//    - Tags with another OC_ID are ignored silently.
//  - WAIT exit: go to DISP the cycle after need is met, where need = got1 (nsrc==1) or got1&got2 (nsrc==2).
//    - A response arriving in the last WAIT cycle counts: capture and transition happen on the same edge.
//    - The two sources may return in either order; they never arrive in the same cycle (one bank port).
//  - DISP:
//    - ex_valid=1 with warp/dst/op1/op2 held stable until ex_ready.
//    - On handshake go to IDLE; alloc_ready=1 in the next cycle.
//    - Minimum occupancy for nsrc=2 with zero-wait FIFO/bank and immediate ex_ready:
//      REQ 1 + WAIT 2 + DISP 1 = 4 cycles.
//  - err is set, and held until rst, on a response tagged with this OC_ID when any one of these holds:
//    - state is not WAIT;
//    - sel=1 with nsrc<2;
//    - the operand was already captured.
//    The offending data is dropped and state is unchanged.
//  - No combinational path from rsp_* or ex_ready to req_*/alloc_ready.
// TESTING
//  T1 reset: assert rst 2 cycles mid-WAIT -> next cycle alloc_ready=1, req_valid=0, ex_valid=0, err=0.
//  T2 OC_ID=3, nsrc=2, src1=5, src2=2, req_ready=1 -> one cycle req_valid, req_2op=1, tags 4'h6/4'h7;
//     rsp 4'h7 data A then 4'h6 data B -> ex_valid, op1=B, op2=A, dst passthrough.
//  T3 req_ready=0 for 4 cycles then 1 -> req_* stable all 5 cycles, single handshake, WAIT entered once.
//  T4 nsrc=1, rsp for OC_ID 2 (foreign) then 4'h6 -> foreign ignored, op1 captured, op2=0, err=0.
//  T5 nsrc=0 -> no req_valid, ex_valid the cycle after alloc; ex_ready=0 for 3 cycles -> outputs held.
//  T6 duplicate 4'h6 in WAIT, and 4'h6 while IDLE -> err=1 stays set; op1 keeps the first value.

Source files
------------

// File: rtl/operand_collector_unit_if.sv
// Handshake and data bundle between one operand-collector slot and the issue/bank/execute paths.
// The master modport is the collector's view of the bundle; the slave modport is the environment's view.
interface operand_collector_unit_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ROW_W  = 3,
  parameter int unsigned WARP_W = 3
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [WARP_W-1:0] alloc_warp;
  logic [1:0]        alloc_nsrc;
  logic [ROW_W-1:0]  alloc_src1;
  logic [ROW_W-1:0]  alloc_src2;
  logic [ROW_W-1:0]  alloc_dst;

  logic              req_valid;
  logic              req_ready;
  logic              req_2op;
  logic [ROW_W-1:0]  req_row1;
  logic [ROW_W-1:0]  req_row2;
  logic [3:0]        req_tag1;
  logic [3:0]        req_tag2;

  logic              rsp_valid;
  logic [3:0]        rsp_tag;
  logic [DATA_W-1:0] rsp_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [WARP_W-1:0] ex_warp;
  logic [ROW_W-1:0]  ex_dst;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;

  logic              err;

  modport master (
    input  alloc_valid, alloc_warp, alloc_nsrc, alloc_src1, alloc_src2, alloc_dst,
    input  req_ready, rsp_valid, rsp_tag, rsp_data, ex_ready,
    output alloc_ready, req_valid, req_2op, req_row1, req_row2, req_tag1, req_tag2,
    output ex_valid, ex_warp, ex_dst, ex_op1, ex_op2, err
  );

  modport slave (
    output alloc_valid, alloc_warp, alloc_nsrc, alloc_src1, alloc_src2, alloc_dst,
    output req_ready, rsp_valid, rsp_tag, rsp_data, ex_ready,
    input  alloc_ready, req_valid, req_2op, req_row1, req_row2, req_tag1, req_tag2,
    input  ex_valid, ex_warp, ex_dst, ex_op1, ex_op2, err
  );
endinterface

// File: rtl/operand_collector_unit.sv
// One operand-collector slot: latches an issued instruction, requests its source rows from the
// RF bank, captures tagged read data and dispatches the complete operand set to execution.
module operand_collector_unit #(
  parameter logic [2:0]  OC_ID  = 3'd0,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ROW_W  = 3,
  parameter int unsigned WARP_W = 3
) (
  input logic                      clk,
  input logic                      rst,
  operand_collector_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISP
  } state_t;

  state_t            state;
  logic              req_valid;
  logic              req_2op;
  logic              ex_valid;
  logic              err;
  logic              need2;
  logic              got1;
  logic              got2;
  logic [WARP_W-1:0] warp;
  logic [ROW_W-1:0]  row1;
  logic [ROW_W-1:0]  row2;
  logic [ROW_W-1:0]  dst;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  logic rsp_hit;
  logic rsp_sel;
  logic rsp_ok;
  logic cap1;
  logic cap2;
  logic have_all;

  // A hit that is not acceptable (wrong state, unexpected src2, or repeat) only raises err.
  always_comb begin
    rsp_hit  = bus.rsp_valid && (bus.rsp_tag[3:1] == OC_ID);
    rsp_sel  = bus.rsp_tag[0];
    rsp_ok   = rsp_hit && (state == S_WAIT) && !(rsp_sel && !need2) &&
               !(rsp_sel ? got2 : got1);
    cap1     = rsp_ok && !rsp_sel;
    cap2     = rsp_ok && rsp_sel;
    have_all = (got1 || cap1) && (!need2 || got2 || cap2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_2op   <= 1'b0;
      ex_valid  <= 1'b0;
      err       <= 1'b0;
      need2     <= 1'b0;
      got1      <= 1'b0;
      got2      <= 1'b0;
      warp      <= '0;
      row1      <= '0;
      row2      <= '0;
      dst       <= '0;
      op1       <= '0;
      op2       <= '0;
    end else begin
      if (rsp_hit && !rsp_ok) begin
        err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.alloc_valid) begin
            warp  <= bus.alloc_warp;
            row1  <= bus.alloc_src1;
            row2  <= bus.alloc_src2;
            dst   <= bus.alloc_dst;
            need2 <= bus.alloc_nsrc[1];
            got1  <= 1'b0;
            got2  <= 1'b0;
            op1   <= '0;
            op2   <= '0;
            if (bus.alloc_nsrc == 2'd0) begin
              state    <= S_DISP;
              ex_valid <= 1'b1;
            end else begin
              state     <= S_REQ;
              req_valid <= 1'b1;
              req_2op   <= bus.alloc_nsrc[1];
            end
          end
        end
        S_REQ: begin
          if (bus.req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cap1) begin
            op1  <= bus.rsp_data;
            got1 <= 1'b1;
          end
          if (cap2) begin
            op2  <= bus.rsp_data;
            got2 <= 1'b1;
          end
          // The completing response is captured and the slot advances on the same edge.
          if (have_all) begin
            state    <= S_DISP;
            ex_valid <= 1'b1;
          end
        end
        S_DISP: begin
          if (bus.ex_ready) begin
            state    <= S_IDLE;
            ex_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alloc_ready = (state == S_IDLE);
  assign bus.req_valid   = req_valid;
  assign bus.req_2op     = req_2op;
  assign bus.req_row1    = row1;
  assign bus.req_row2    = row2;
  assign bus.req_tag1    = {OC_ID, 1'b0};
  assign bus.req_tag2    = {OC_ID, 1'b1};
  assign bus.ex_valid    = ex_valid;
  assign bus.ex_warp     = warp;
  assign bus.ex_dst      = dst;
  assign bus.ex_op1      = op1;
  assign bus.ex_op2      = op2;
  assign bus.err         = err;

endmodule

// File: tb/tb_operand_collector_unit.sv
// Directed bench for operand_collector_unit (OC_ID=3) with a transaction-level reference model
// compared on every cycle plus literal expectations at key points.
module tb_operand_collector_unit;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned WARP_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  operand_collector_unit_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .WARP_W(WARP_W)) bus ();

  operand_collector_unit #(
    .OC_ID(3'd3), .DATA_W(DATA_W), .ROW_W(ROW_W), .WARP_W(WARP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one pending instruction described by flags, not by a state encoding.
  logic         m_active, m_reqd, m_got1, m_got2, m_err;
  int           m_nsrc;
  logic [2:0]   m_warp, m_row1, m_row2, m_dst;
  logic [255:0] m_op1, m_op2;

  function automatic logic m_complete();
    return (m_nsrc == 0) || (m_got1 && (m_nsrc == 1 || m_got2));
  endfunction

  always @(posedge clk) begin
    logic idle_ph, req_ph, wait_ph, disp_ph, sel, have;
    if (rst) begin
      m_active = 0; m_reqd = 0; m_got1 = 0; m_got2 = 0; m_err = 0; m_nsrc = 0;
      m_warp = '0; m_row1 = '0; m_row2 = '0; m_dst = '0; m_op1 = '0; m_op2 = '0;
    end else begin
      idle_ph = !m_active;
      req_ph  = m_active && m_nsrc != 0 && !m_reqd;
      wait_ph = m_active && m_reqd && !m_complete();
      disp_ph = m_active && m_complete();
      if (bus.rsp_valid && bus.rsp_tag[3:1] == 3'd3) begin
        sel  = bus.rsp_tag[0];
        have = sel ? m_got2 : m_got1;
        if (wait_ph && !(sel && m_nsrc < 2) && !have) begin
          if (sel) begin m_op2 = bus.rsp_data; m_got2 = 1; end
          else     begin m_op1 = bus.rsp_data; m_got1 = 1; end
        end else begin
          m_err = 1;
        end
      end
      if (req_ph && bus.req_ready) m_reqd = 1;
      if (disp_ph && bus.ex_ready) m_active = 0;
      if (idle_ph && bus.alloc_valid) begin
        m_active = 1; m_reqd = 0; m_got1 = 0; m_got2 = 0;
        m_nsrc = (bus.alloc_nsrc == 2'd3) ? 2 : int'(bus.alloc_nsrc);
        m_warp = bus.alloc_warp; m_row1 = bus.alloc_src1; m_row2 = bus.alloc_src2;
        m_dst = bus.alloc_dst; m_op1 = '0; m_op2 = '0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic exp_req, exp_ex;
      exp_req = m_active && m_nsrc != 0 && !m_reqd;
      exp_ex  = m_active && m_complete();
      check("alloc_ready", 256'(bus.alloc_ready), 256'(!m_active));
      check("req_valid", 256'(bus.req_valid), 256'(exp_req));
      check("ex_valid", 256'(bus.ex_valid), 256'(exp_ex));
      check("err", 256'(bus.err), 256'(m_err));
      if (exp_req) begin
        check("req_2op", 256'(bus.req_2op), 256'(m_nsrc == 2));
        check("req_row1", 256'(bus.req_row1), 256'(m_row1));
        check("req_row2", 256'(bus.req_row2), 256'(m_row2));
        check("req_tag1", 256'(bus.req_tag1), 256'(4'h6));
        check("req_tag2", 256'(bus.req_tag2), 256'(4'h7));
      end
      if (exp_ex) begin
        check("ex_warp", 256'(bus.ex_warp), 256'(m_warp));
        check("ex_dst", 256'(bus.ex_dst), 256'(m_dst));
        check("ex_op1", bus.ex_op1, m_op1);
        check("ex_op2", bus.ex_op2, m_op2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] w, input logic [1:0] n, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] d);
    int unsigned budget = 0;
    while (!bus.alloc_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!bus.alloc_ready) begin
      checks++;
      errors++;
      $display("FAIL alloc_wait: alloc_ready got 0 expected 1 within 50 cycles");
    end
    bus.alloc_valid = 1'b1;
    bus.alloc_warp  = w;
    bus.alloc_nsrc  = n;
    bus.alloc_src1  = s1;
    bus.alloc_src2  = s2;
    bus.alloc_dst   = d;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [3:0] t, input logic [255:0] d);
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = t;
    bus.rsp_data  = d;
    tick();
    bus.rsp_valid = 1'b0;
  endtask

  logic [255:0] da, db, dc, dd, de, df, dx, dy, dz, dw;

  initial begin
    da = {8{32'hA0A0_0001}}; db = {8{32'hB0B0_0002}}; dc = {8{32'hC0C0_0003}};
    dd = {8{32'hD0D0_0004}}; de = {8{32'hE0E0_0005}}; df = {8{32'hF0F0_0006}};
    dx = {8{32'h1111_0007}}; dy = {8{32'h2222_0008}}; dz = {8{32'h3333_0009}};
    dw = {8{32'h4444_000A}};
    bus.alloc_valid = 0; bus.alloc_warp = '0; bus.alloc_nsrc = '0; bus.alloc_src1 = '0;
    bus.alloc_src2 = '0; bus.alloc_dst = '0; bus.req_ready = 1; bus.rsp_valid = 0;
    bus.rsp_tag = '0; bus.rsp_data = '0; bus.ex_ready = 1;
    tick(); tick();
    rst = 0;
    check("lit_reset_alloc_ready", 256'(bus.alloc_ready), 256'(1'b1));
    check("lit_reset_err", 256'(bus.err), 256'(1'b0));

    // Two sources returned out of order
    do_alloc(3'd1, 2'd2, 3'd5, 3'd2, 3'd4);
    check("lit_t2_req_valid", 256'(bus.req_valid), 256'(1'b1));
    check("lit_t2_req_2op", 256'(bus.req_2op), 256'(1'b1));
    check("lit_t2_tag1", 256'(bus.req_tag1), 256'(4'h6));
    check("lit_t2_tag2", 256'(bus.req_tag2), 256'(4'h7));
    check("lit_t2_row1", 256'(bus.req_row1), 256'(3'd5));
    tick();
    check("lit_t2_req_drop", 256'(bus.req_valid), 256'(1'b0));
    send_rsp(4'h7, da);
    check("lit_t2_not_yet", 256'(bus.ex_valid), 256'(1'b0));
    send_rsp(4'h6, db);
    check("lit_t2_ex_valid", 256'(bus.ex_valid), 256'(1'b1));
    check("lit_t2_op1", bus.ex_op1, db);
    check("lit_t2_op2", bus.ex_op2, da);
    check("lit_t2_dst", 256'(bus.ex_dst), 256'(3'd4));
    tick();
    check("lit_t2_idle", 256'(bus.alloc_ready), 256'(1'b1));

    // Request back-pressure
    bus.req_ready = 0;
    do_alloc(3'd2, 2'd2, 3'd3, 3'd6, 3'd1);
    for (int i = 0; i < 4; i++) begin
      check("lit_t3_req_hold", 256'(bus.req_valid), 256'(1'b1));
      check("lit_t3_row2_hold", 256'(bus.req_row2), 256'(3'd6));
      tick();
    end
    bus.req_ready = 1;
    check("lit_t3_req_fifth", 256'(bus.req_valid), 256'(1'b1));
    tick();
    check("lit_t3_req_done", 256'(bus.req_valid), 256'(1'b0));
    tick();
    send_rsp(4'h6, dc);
    send_rsp(4'h7, dd);
    check("lit_t3_op2", bus.ex_op2, dd);
    tick();

    // Single source with a foreign response
    do_alloc(3'd3, 2'd1, 3'd1, 3'd0, 3'd5);
    tick();
    send_rsp(4'h4, dc);
    check("lit_t4_foreign_ex", 256'(bus.ex_valid), 256'(1'b0));
    check("lit_t4_foreign_err", 256'(bus.err), 256'(1'b0));
    send_rsp(4'h6, dd);
    check("lit_t4_op1", bus.ex_op1, dd);
    check("lit_t4_op2", bus.ex_op2, 256'd0);
    tick();

    // No sources, execution stalled
    bus.ex_ready = 0;
    do_alloc(3'd6, 2'd0, 3'd0, 3'd0, 3'd7);
    check("lit_t5_no_req", 256'(bus.req_valid), 256'(1'b0));
    check("lit_t5_ex_valid", 256'(bus.ex_valid), 256'(1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit_t5_hold_dst", 256'(bus.ex_dst), 256'(3'd7));
      check("lit_t5_hold_op1", bus.ex_op1, 256'd0);
    end
    bus.ex_ready = 1;
    tick();
    check("lit_t5_idle", 256'(bus.alloc_ready), 256'(1'b1));

    // src2 response for a one-source instruction
    do_alloc(3'd0, 2'd1, 3'd2, 3'd0, 3'd2);
    tick();
    send_rsp(4'h7, de);
    check("lit_sel1_err", 256'(bus.err), 256'(1'b1));
    check("lit_sel1_ex", 256'(bus.ex_valid), 256'(1'b0));
    send_rsp(4'h6, df);
    check("lit_sel1_op2", bus.ex_op2, 256'd0);
    tick();

    // Reset mid-WAIT abandons the instruction and clears err
    do_alloc(3'd1, 2'd2, 3'd4, 3'd5, 3'd6);
    tick();
    send_rsp(4'h6, da);
    rst = 1;
    tick(); tick();
    rst = 0;
    check("lit_t1_alloc_ready", 256'(bus.alloc_ready), 256'(1'b1));
    check("lit_t1_req_valid", 256'(bus.req_valid), 256'(1'b0));
    check("lit_t1_ex_valid", 256'(bus.ex_valid), 256'(1'b0));
    check("lit_t1_err", 256'(bus.err), 256'(1'b0));
    tick();
    check("lit_t1_no_disp", 256'(bus.ex_valid), 256'(1'b0));

    // Duplicate capture and response while idle
    do_alloc(3'd5, 2'd2, 3'd7, 3'd1, 3'd3);
    tick();
    send_rsp(4'h6, dx);
    send_rsp(4'h6, dy);
    check("lit_t6_dup_err", 256'(bus.err), 256'(1'b1));
    send_rsp(4'h7, dz);
    check("lit_t6_op1_first", bus.ex_op1, dx);
    check("lit_t6_op2", bus.ex_op2, dz);
    tick();
    send_rsp(4'h6, dw);
    check("lit_t6_idle_err", 256'(bus.err), 256'(1'b1));
    check("lit_t6_idle_ready", 256'(bus.alloc_ready), 256'(1'b1));

    // nsrc=3 behaves as two sources
    do_alloc(3'd4, 2'd3, 3'd6, 3'd5, 3'd0);
    check("lit_n3_2op", 256'(bus.req_2op), 256'(1'b1));
    tick();
    send_rsp(4'h7, da);
    send_rsp(4'h6, dc);
    check("lit_n3_op2", bus.ex_op2, da);
    tick();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
